trigger_sequencer: RTL and testbench

Command-driven controller that configures and sequences the 4-stage trigger and the capture that follows it.
- Decodes host commands into per-stage mask/value/config write strobes and the trigger arm pulse.
- After the trigger fires, counts post-trigger samples into sample memory, then runs a handshaked readout of the captured samples.
- Sits between the host command decoder and the trigger/sample-memory datapath.

---
 rtl/trigger_sequencer_if.sv | 25 ++
 rtl/trigger_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_sequencer_if.sv
// Host-side command bus and readout handshake shared by the trigger sequencer and its host.
// The master drives commands and acknowledges reads; the sequencer owns rd_valid.
interface trigger_sequencer_if;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        rd_valid;
    logic        rd_ack;

    modport master (
        output cmd_valid,
        output cmd_opcode,
        output cmd_data,
        output rd_ack,
        input  rd_valid
    );

    modport slave (
        input  cmd_valid,
        input  cmd_opcode,
        input  cmd_data,
        input  rd_ack,
        output rd_valid
    );
endinterface

// File: rtl/trigger_sequencer.sv
// Command decoder and capture sequencer: programs the 4 trigger stages, arms the trigger,
// counts post-trigger samples into memory and then hands the capture out one read at a time.
module trigger_sequencer #(
    parameter int DELAY_W = 16,
    parameter int READ_W  = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    trigger_sequencer_if.slave   bus,
    output logic [31:0]          trig_data,
    output logic [3:0]           trig_wr_mask,
    output logic [3:0]           trig_wr_value,
    output logic [3:0]           trig_wr_config,
    output logic                 trig_arm,
    input  logic                 trig_run,
    input  logic                 sample_ready,
    output logic                 mem_write,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t               state;
    logic [DELAY_W-1:0]   delayReg;
    logic [READ_W-1:0]    readReg;
    logic [DELAY_W-1:0]   delayCnt;
    logic [READ_W-1:0]    readCnt;
    logic                 rdValid;

    logic                 isAbort;
    logic                 isArm;
    logic                 isLoad;
    logic                 isStageWr;
    logic [3:0]           stageSel;

    function automatic logic [3:0] stageOneHot(input logic [1:0] stage);
        logic [3:0] sel;
        case (stage)
            2'd0:    sel = 4'b0001;
            2'd1:    sel = 4'b0010;
            2'd2:    sel = 4'b0100;
            2'd3:    sel = 4'b1000;
            default: sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Opcode decode; stage writes use 0xC0..0xCE with the low two bits picking mask/value/config.
    always_comb begin
        isAbort   = 1'b0;
        isArm     = 1'b0;
        isLoad    = 1'b0;
        isStageWr = 1'b0;
        stageSel  = stageOneHot(bus.cmd_opcode[3:2]);
        if (bus.cmd_valid) begin
            isAbort   = (bus.cmd_opcode == 8'h00);
            isArm     = (bus.cmd_opcode == 8'h01);
            isLoad    = (bus.cmd_opcode == 8'h83);
            isStageWr = (bus.cmd_opcode[7:4] == 4'hC) && (bus.cmd_opcode[1:0] != 2'd3);
        end else begin
            isAbort   = 1'b0;
        end
    end

    // Samples are stored only while waiting for or counting after the trigger.
    assign mem_write    = sample_ready && ((state == ARMED) || (state == DELAY));
    assign bus.rd_valid = rdValid;

    // Sequencer state, counters and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            delayReg       <= {DELAY_W{1'b0}};
            readReg        <= {READ_W{1'b0}};
            delayCnt       <= {DELAY_W{1'b0}};
            readCnt        <= {READ_W{1'b0}};
            rdValid        <= 1'b0;
            trig_data      <= 32'd0;
            trig_wr_mask   <= 4'd0;
            trig_wr_value  <= 4'd0;
            trig_wr_config <= 4'd0;
            trig_arm       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            trig_wr_mask   <= 4'd0;
            trig_wr_value  <= 4'd0;
            trig_wr_config <= 4'd0;
            trig_arm       <= 1'b0;
            done           <= 1'b0;

            if (isAbort) begin
                state   <= IDLE;
                rdValid <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        busy    <= 1'b0;
                        rdValid <= 1'b0;
                        if (isStageWr) begin
                            trig_data <= bus.cmd_data;
                            case (bus.cmd_opcode[1:0])
                                2'd0:    trig_wr_mask   <= stageSel;
                                2'd1:    trig_wr_value  <= stageSel;
                                2'd2:    trig_wr_config <= stageSel;
                                default: trig_wr_mask   <= 4'd0;
                            endcase
                        end else if (isLoad) begin
                            delayReg <= DELAY_W'(bus.cmd_data[31:16]);
                            readReg  <= READ_W'(bus.cmd_data[15:0]);
                        end else if (isArm) begin
                            trig_arm <= 1'b1;
                            state    <= ARMED;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end

                    ARMED: begin
                        if (trig_run) begin
                            state    <= DELAY;
                            delayCnt <= {DELAY_W{1'b0}};
                        end else begin
                            state <= ARMED;
                        end
                    end

                    DELAY: begin
                        // The terminal compare precedes the increment, so delayCnt never wraps.
                        if (sample_ready) begin
                            if (delayCnt == delayReg) begin
                                state   <= READ;
                                readCnt <= {READ_W{1'b0}};
                                rdValid <= 1'b1;
                            end else begin
                                delayCnt <= delayCnt + DELAY_W'(1);
                            end
                        end else begin
                            state <= DELAY;
                        end
                    end

                    READ: begin
                        if (rdValid) begin
                            if (bus.rd_ack) begin
                                rdValid <= 1'b0;
                                if (readCnt == readReg) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    readCnt <= readCnt + READ_W'(1);
                                end
                            end else begin
                                rdValid <= 1'b1;
                            end
                        end else begin
                            // One idle cycle after each ack, then request the next sample.
                            rdValid <= 1'b1;
                        end
                    end

                    default: begin
                        state   <= IDLE;
                        rdValid <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: stage writes, arm/delay/readout, abort and async reset.
module tb_trigger_sequencer;

    logic        clock;
    logic        reset_n;
    logic [31:0] trig_data;
    logic [3:0]  trig_wr_mask;
    logic [3:0]  trig_wr_value;
    logic [3:0]  trig_wr_config;
    logic        trig_arm;
    logic        trig_run;
    logic        sample_ready;
    logic        mem_write;
    logic        busy;
    logic        done;

    int testsRun    = 0;
    int testsFailed = 0;
    int writes;
    int acks;

    trigger_sequencer_if bus ();

    trigger_sequencer #(.DELAY_W(16), .READ_W(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .bus            (bus),
        .trig_data      (trig_data),
        .trig_wr_mask   (trig_wr_mask),
        .trig_wr_value  (trig_wr_value),
        .trig_wr_config (trig_wr_config),
        .trig_arm       (trig_arm),
        .trig_run       (trig_run),
        .sample_ready   (sample_ready),
        .mem_write      (mem_write),
        .busy           (busy),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sendCmd(input logic [7:0] op, input logic [31:0] data);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = op;
        bus.cmd_data   = data;
        step();
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = 8'h00;
        bus.cmd_data   = 32'd0;
    endtask

    task automatic pulseSamples(input int n, output int count);
        count = 0;
        for (int i = 0; i < n; i++) begin
            sample_ready = 1'b1;
            #1;
            if (mem_write) count++;
            step();
            sample_ready = 1'b0;
            step();
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = 8'h00;
        bus.cmd_data   = 32'd0;
        bus.rd_ack     = 1'b0;
        trig_run       = 1'b0;
        sample_ready   = 1'b0;
        #2;
        check("rst_trig_data", trig_data, 32'd0);
        check("rst_strobes", {20'd0, trig_wr_mask, trig_wr_value, trig_wr_config}, 32'd0);
        check("rst_ctrl", {27'd0, trig_arm, mem_write, bus.rd_valid, busy, done}, 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // Scenario 1: mask write for stage 1.
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 8'hC4;
        bus.cmd_data   = 32'h0000_00FF;
        #1;
        check("s1_no_strobe_on_cmd", {28'd0, trig_wr_mask}, 32'd0);
        step();
        bus.cmd_valid = 1'b0;
        check("s1_trig_data", trig_data, 32'h0000_00FF);
        check("s1_mask", {28'd0, trig_wr_mask}, 32'h2);
        check("s1_other", {24'd0, trig_wr_value, trig_wr_config}, 32'd0);
        step();
        check("s1_mask_one_cycle", {28'd0, trig_wr_mask}, 32'd0);
        sendCmd(8'hCE, 32'h1234_5678);
        check("s1_cfg_stage3", {28'd0, trig_wr_config}, 32'h8);
        check("s1_cfg_data", trig_data, 32'h1234_5678);
        sendCmd(8'hCD, 32'hA5A5_0000);
        check("s1_val_stage3", {28'd0, trig_wr_value}, 32'h8);
        sendCmd(8'hC3, 32'hDEAD_BEEF);
        check("s1_bad_op_strobes", {20'd0, trig_wr_mask, trig_wr_value, trig_wr_config}, 32'd0);
        check("s1_bad_op_data", trig_data, 32'hA5A5_0000);

        // Scenario 2: delay 3, read 1 -> 4 writes in DELAY.
        sendCmd(8'h83, 32'h0003_0001);
        sendCmd(8'h01, 32'd0);
        check("s2_arm_pulse", {31'd0, trig_arm}, 32'd1);
        check("s2_busy", {31'd0, busy}, 32'd1);
        step();
        check("s2_arm_once", {31'd0, trig_arm}, 32'd0);
        sendCmd(8'hC2, 32'h0000_0001);
        check("s2_drop_cfg_armed", {28'd0, trig_wr_config}, 32'd0);
        trig_run = 1'b1;
        step();
        trig_run = 1'b0;
        pulseSamples(6, writes);
        check("s2_writes", writes, 32'd4);
        check("s2_in_read", {31'd0, bus.rd_valid}, 32'd1);

        // Scenario 3: two acknowledged reads, ack two cycles after rd_valid.
        acks = 0;
        step();
        step();
        bus.rd_ack = 1'b1;
        #1;
        if (bus.rd_valid) acks++;
        step();
        bus.rd_ack = 1'b0;
        check("s3_rdv_drop", {30'd0, bus.rd_valid, done}, 32'd0);
        step();
        check("s3_rdv_reassert", {31'd0, bus.rd_valid}, 32'd1);
        step();
        step();
        bus.rd_ack = 1'b1;
        #1;
        if (bus.rd_valid) acks++;
        step();
        bus.rd_ack = 1'b0;
        check("s3_acks", acks, 32'd2);
        check("s3_done", {31'd0, done}, 32'd1);
        check("s3_busy_idle", {30'd0, busy, bus.rd_valid}, 32'd0);
        bus.rd_ack = 1'b1;
        step();
        bus.rd_ack = 1'b0;
        check("s3_done_once", {31'd0, done}, 32'd0);

        // Scenario 4: delay 0, trig_run with a sample in ARMED.
        sendCmd(8'h83, 32'h0000_0000);
        sendCmd(8'h01, 32'd0);
        trig_run     = 1'b1;
        sample_ready = 1'b1;
        #1;
        check("s4_armed_write", {31'd0, mem_write}, 32'd1);
        step();
        trig_run     = 1'b0;
        sample_ready = 1'b0;
        step();
        pulseSamples(2, writes);
        check("s4_delay_writes", writes, 32'd1);
        check("s4_read", {31'd0, bus.rd_valid}, 32'd1);

        // Scenario 5: abort together with the final ack.
        bus.rd_ack     = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 8'h00;
        step();
        bus.rd_ack     = 1'b0;
        bus.cmd_valid  = 1'b0;
        check("s5_abort_state", {29'd0, bus.rd_valid, busy, done}, 32'd0);
        step();
        check("s5_no_done", {31'd0, done}, 32'd0);
        trig_run = 1'b1;
        step();
        step();
        check("s5_run_in_idle", {30'd0, busy, trig_arm}, 32'd0);
        trig_run = 1'b0;
        sendCmd(8'h01, 32'd0);
        check("s5_rearm", {30'd0, trig_arm, busy}, 32'h3);
        sendCmd(8'h00, 32'd0);
        check("s5_abort_armed", {31'd0, busy}, 32'd0);

        // Scenario 6: async reset during DELAY restores defaults.
        sendCmd(8'hC8, 32'hCAFE_F00D);
        sendCmd(8'h83, 32'h0005_0002);
        sendCmd(8'h01, 32'd0);
        trig_run = 1'b1;
        step();
        trig_run = 1'b0;
        pulseSamples(1, writes);
        check("s6_busy_delay", {31'd0, busy}, 32'd1);
        sample_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_rst_data", trig_data, 32'd0);
        check("s6_rst_ctrl", {27'd0, trig_arm, mem_write, bus.rd_valid, busy, done}, 32'd0);
        sample_ready = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        sendCmd(8'h01, 32'd0);
        trig_run = 1'b1;
        step();
        trig_run = 1'b0;
        pulseSamples(3, writes);
        check("s6_default_delay", writes, 32'd1);
        check("s6_read", {31'd0, bus.rd_valid}, 32'd1);
        bus.rd_ack = 1'b1;
        step();
        bus.rd_ack = 1'b0;
        check("s6_default_read", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
